// File: rtl/regfile_scoreboard.sv
// Dual-issue register scoreboard: per-register in-flight write counters that
// gate per-slot issue grants and retire on the two writeback ports.
module regfile_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     issue_valid_1,
    input  logic                     issue_valid_2,
    input  logic [$clog2(NREG)-1:0]  issue_src1_1,
    input  logic [$clog2(NREG)-1:0]  issue_src2_1,
    input  logic [$clog2(NREG)-1:0]  issue_src1_2,
    input  logic [$clog2(NREG)-1:0]  issue_src2_2,
    input  logic [1:0]               issue_rs_en_1,
    input  logic [1:0]               issue_rs_en_2,
    input  logic [$clog2(NREG)-1:0]  issue_dst_1,
    input  logic [$clog2(NREG)-1:0]  issue_dst_2,
    input  logic                     issue_wen_1,
    input  logic                     issue_wen_2,
    input  logic                     allow_in,
    output logic                     issue_ok_1,
    output logic                     issue_ok_2,
    input  logic                     wb_valid_1,
    input  logic                     wb_valid_2,
    input  logic [$clog2(NREG)-1:0]  wb_dst_1,
    input  logic [$clog2(NREG)-1:0]  wb_dst_2,
    input  logic                     flush,
    output logic [NREG-1:0]          pending_mask,
    output logic                     sb_busy,
    output logic                     sb_err
);
    localparam int AW   = $clog2(NREG);
    localparam int CMAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] CMAX_V  = CNT_W'(CMAX);
    localparam logic [CNT_W-1:0] CMAX_M2 = CNT_W'(CMAX - 2);

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  mask_nxt;
    logic             err_v;
    int               inc_v, dec_v, sum_v;

    logic src_ok_1, src_ok_2, dst_ok_1, dst_ok_2, raw_12, same_dst;
    logic fire_1, fire_2;

    // cnt[0] is held at zero, so reads of r0 never block.
    assign src_ok_1 = !(issue_rs_en_1[0] && issue_src1_1 != '0 && cnt[issue_src1_1] != '0) &&
                      !(issue_rs_en_1[1] && issue_src2_1 != '0 && cnt[issue_src2_1] != '0);
    assign src_ok_2 = !(issue_rs_en_2[0] && issue_src1_2 != '0 && cnt[issue_src1_2] != '0) &&
                      !(issue_rs_en_2[1] && issue_src2_2 != '0 && cnt[issue_src2_2] != '0);

    assign dst_ok_1 = !(issue_wen_1 && issue_dst_1 != '0) || (cnt[issue_dst_1] < CMAX_V);

    assign raw_12   = issue_wen_1 && issue_dst_1 != '0 &&
                      ((issue_rs_en_2[0] && issue_src1_2 == issue_dst_1) ||
                       (issue_rs_en_2[1] && issue_src2_2 == issue_dst_1));

    // Both slots allocating the same register need two free counter steps.
    assign same_dst = issue_wen_1 && issue_wen_2 && issue_dst_2 == issue_dst_1;
    assign dst_ok_2 = !(issue_wen_2 && issue_dst_2 != '0) ||
                      (same_dst ? (cnt[issue_dst_2] <= CMAX_M2) : (cnt[issue_dst_2] < CMAX_V));

    assign issue_ok_1 = issue_valid_1 && src_ok_1 && dst_ok_1;
    assign issue_ok_2 = issue_ok_1 && issue_valid_2 && src_ok_2 && !raw_12 && dst_ok_2;

    assign fire_1 = issue_ok_1 && allow_in;
    assign fire_2 = issue_ok_2 && allow_in;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        err_v    = 1'b0;
        inc_v    = 0;
        dec_v    = 0;
        sum_v    = 0;
        mask_nxt = '0;
        for (int r = 0; r < NREG; r++) cnt_nxt[r] = '0;
        if (!flush) begin
            for (int r = 1; r < NREG; r++) begin
                inc_v = 0;
                dec_v = 0;
                if (fire_1 && issue_wen_1 && issue_dst_1 == AW'(r)) inc_v = inc_v + 1;
                if (fire_2 && issue_wen_2 && issue_dst_2 == AW'(r)) inc_v = inc_v + 1;
                if (wb_valid_1 && wb_dst_1 == AW'(r)) dec_v = dec_v + 1;
                if (wb_valid_2 && wb_dst_2 == AW'(r)) dec_v = dec_v + 1;
                sum_v = int'(cnt[r]) + inc_v - dec_v;
                if (sum_v < 0) begin
                    cnt_nxt[r] = '0;
                    err_v      = 1'b1;
                end else if (sum_v > CMAX) begin
                    cnt_nxt[r] = CMAX_V;
                    err_v      = 1'b1;
                end else begin
                    cnt_nxt[r] = sum_v[CNT_W-1:0];
                end
                mask_nxt[r] = (cnt_nxt[r] != '0);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the counter array is plain flops, not RAM, so it is reset with everything else.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            pending_mask <= '0;
            sb_busy      <= 1'b0;
            sb_err       <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
            pending_mask <= mask_nxt;
            sb_busy      <= |mask_nxt;
            sb_err       <= sb_err | err_v;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed test-plan steps followed
// by random traffic, all checked against an occupancy-count reference model.
module tb_regfile_scoreboard;
    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        issue_valid_1, issue_valid_2;
    logic [4:0]  issue_src1_1, issue_src2_1, issue_src1_2, issue_src2_2;
    logic [1:0]  issue_rs_en_1, issue_rs_en_2;
    logic [4:0]  issue_dst_1, issue_dst_2;
    logic        issue_wen_1, issue_wen_2;
    logic        allow_in;
    logic        issue_ok_1, issue_ok_2;
    logic        wb_valid_1, wb_valid_2;
    logic [4:0]  wb_dst_1, wb_dst_2;
    logic        flush;
    logic [31:0] pending_mask;
    logic        sb_busy, sb_err;

    int checks = 0;
    int errors = 0;
    int mcnt [32];
    bit merr;
    bit m_ok1, m_ok2;

    always #5 clk = ~clk;

    regfile_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .issue_valid_1(issue_valid_1), .issue_valid_2(issue_valid_2),
        .issue_src1_1(issue_src1_1), .issue_src2_1(issue_src2_1),
        .issue_src1_2(issue_src1_2), .issue_src2_2(issue_src2_2),
        .issue_rs_en_1(issue_rs_en_1), .issue_rs_en_2(issue_rs_en_2),
        .issue_dst_1(issue_dst_1), .issue_dst_2(issue_dst_2),
        .issue_wen_1(issue_wen_1), .issue_wen_2(issue_wen_2),
        .allow_in(allow_in),
        .issue_ok_1(issue_ok_1), .issue_ok_2(issue_ok_2),
        .wb_valid_1(wb_valid_1), .wb_valid_2(wb_valid_2),
        .wb_dst_1(wb_dst_1), .wb_dst_2(wb_dst_2),
        .flush(flush),
        .pending_mask(pending_mask), .sb_busy(sb_busy), .sb_err(sb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit blocked(input bit en, input int r);
        return en && r != 0 && mcnt[r] != 0;
    endfunction

    // Grants from the rules: free sources, no bundle hazard, enough headroom.
    task automatic model_grant();
        int need;
        m_ok1 = issue_valid_1 && !blocked(issue_rs_en_1[0], issue_src1_1)
                && !blocked(issue_rs_en_1[1], issue_src2_1)
                && !(issue_wen_1 && issue_dst_1 != 0 && mcnt[issue_dst_1] + 1 > CMAX);
        need  = (issue_wen_1 && issue_dst_1 == issue_dst_2) ? 2 : 1;
        m_ok2 = m_ok1 && issue_valid_2 && !blocked(issue_rs_en_2[0], issue_src1_2)
                && !blocked(issue_rs_en_2[1], issue_src2_2)
                && !(issue_wen_1 && issue_dst_1 != 0 &&
                     ((issue_rs_en_2[0] && issue_src1_2 == issue_dst_1) ||
                      (issue_rs_en_2[1] && issue_src2_2 == issue_dst_1)))
                && !(issue_wen_2 && issue_dst_2 != 0 && mcnt[issue_dst_2] + need > CMAX);
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        for (int r = 1; r < 32; r++) m[r] = (mcnt[r] != 0);
        return m;
    endfunction

    task automatic idle();
        issue_valid_1 = 0; issue_valid_2 = 0; issue_wen_1 = 0; issue_wen_2 = 0;
        issue_src1_1 = 0; issue_src2_1 = 0; issue_src1_2 = 0; issue_src2_2 = 0;
        issue_rs_en_1 = 0; issue_rs_en_2 = 0; issue_dst_1 = 0; issue_dst_2 = 0;
        allow_in = 0; wb_valid_1 = 0; wb_valid_2 = 0; wb_dst_1 = 0; wb_dst_2 = 0;
        flush = 0;
    endtask

    task automatic settle(input string tag);
        #1;
        model_grant();
        check({tag, ".ok1"},  32'(issue_ok_1), 32'(m_ok1));
        check({tag, ".ok2"},  32'(issue_ok_2), 32'(m_ok2));
        check({tag, ".mask"}, pending_mask, model_mask());
        check({tag, ".busy"}, 32'(sb_busy), 32'(model_mask() != 0));
        check({tag, ".err"},  32'(sb_err), 32'(merr));
    endtask

    task automatic tick();
        int nxt [32];
        @(posedge clk);
        if (!resetn || flush) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            if (!resetn) merr = 0;
        end else begin
            nxt = mcnt;
            if (m_ok1 && allow_in && issue_wen_1 && issue_dst_1 != 0) nxt[issue_dst_1]++;
            if (m_ok2 && allow_in && issue_wen_2 && issue_dst_2 != 0) nxt[issue_dst_2]++;
            if (wb_valid_1 && wb_dst_1 != 0) nxt[wb_dst_1]--;
            if (wb_valid_2 && wb_dst_2 != 0) nxt[wb_dst_2]--;
            for (int r = 1; r < 32; r++) begin
                if (nxt[r] < 0)    begin nxt[r] = 0;    merr = 1; end
                if (nxt[r] > CMAX) begin nxt[r] = CMAX; merr = 1; end
            end
            mcnt = nxt;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        resetn = 0;
        @(negedge clk);
        tick();
        resetn = 1;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        merr = 0;

        // 1. Reset: registered outputs clear, grants stay combinational.
        idle();
        resetn = 0;
        #2;
        issue_valid_1 = 1; issue_src1_1 = 5; issue_rs_en_1 = 2'b01;
        settle("t1_rst");
        check("t1_ok1_const", 32'(issue_ok_1), 32'd1);
        tick();
        resetn = 1;
        settle("t1_post");

        // 2. RAW across cycles with writeback unblocking one cycle later.
        idle();
        issue_valid_1 = 1; issue_wen_1 = 1; issue_dst_1 = 5; allow_in = 1;
        settle("t2_c0"); tick();
        idle();
        issue_valid_1 = 1; issue_src1_1 = 5; issue_rs_en_1 = 2'b01; allow_in = 1;
        settle("t2_c1");
        check("t2_mask5_c1", 32'(pending_mask[5]), 32'd1);
        check("t2_ok1_c1", 32'(issue_ok_1), 32'd0);
        tick();
        wb_valid_1 = 1; wb_dst_1 = 5;
        settle("t2_c2");
        check("t2_ok1_c2", 32'(issue_ok_1), 32'd0);
        tick();
        wb_valid_1 = 0;
        settle("t2_c3");
        check("t2_ok1_c3", 32'(issue_ok_1), 32'd1);
        check("t2_mask5_c3", 32'(pending_mask[5]), 32'd0);
        tick();

        // 3. Intra-bundle RAW.
        idle();
        issue_valid_1 = 1; issue_wen_1 = 1; issue_dst_1 = 7;
        issue_valid_2 = 1; issue_src2_2 = 7; issue_rs_en_2 = 2'b10; issue_dst_2 = 11; issue_wen_2 = 1;
        settle("t3_raw");
        check("t3_raw_ok1", 32'(issue_ok_1), 32'd1);
        check("t3_raw_ok2", 32'(issue_ok_2), 32'd0);
        issue_src2_2 = 8;
        settle("t3_noraw");
        check("t3_noraw_ok2", 32'(issue_ok_2), 32'd1);
        tick();

        // 4. Same-destination capacity and double retire.
        idle();
        issue_valid_1 = 1; issue_wen_1 = 1; issue_dst_1 = 3; allow_in = 1;
        settle("t4_pre"); tick();
        issue_valid_2 = 1; issue_wen_2 = 1; issue_dst_2 = 3;
        settle("t4_dual");
        check("t4_dual_ok2", 32'(issue_ok_2), 32'd1);
        tick();
        settle("t4_full");
        check("t4_full_ok1", 32'(issue_ok_1), 32'd0);
        tick();
        idle();
        wb_valid_1 = 1; wb_dst_1 = 3; wb_valid_2 = 1; wb_dst_2 = 3;
        settle("t4_wb2"); tick();
        idle();
        issue_valid_1 = 1; issue_wen_1 = 1; issue_dst_1 = 3;
        issue_valid_2 = 1; issue_wen_2 = 1; issue_dst_2 = 3;
        settle("t4_cnt1");
        check("t4_cnt1_ok2", 32'(issue_ok_2), 32'd1);
        check("t4_cnt1_mask3", 32'(pending_mask[3]), 32'd1);
        tick();

        // 6. Register 0 is never tracked.
        idle();
        for (int i = 0; i < 4; i++) begin
            issue_valid_1 = 1; issue_wen_1 = 1; issue_dst_1 = 0;
            issue_src1_1 = 0; issue_rs_en_1 = 2'b11; allow_in = 1;
            issue_valid_2 = 1; issue_wen_2 = 1; issue_dst_2 = 0; issue_rs_en_2 = 2'b11;
            settle("t6_r0");
            check("t6_r0_ok1", 32'(issue_ok_1), 32'd1);
            check("t6_r0_mask0", 32'(pending_mask[0]), 32'd0);
            check("t6_r0_err", 32'(sb_err), 32'd0);
            tick();
        end

        // 5. Flush beats issue; underflow sets a sticky error.
        idle();
        issue_valid_1 = 1; issue_wen_1 = 1; issue_dst_1 = 2;
        issue_valid_2 = 1; issue_wen_2 = 1; issue_dst_2 = 9; allow_in = 1;
        settle("t5_a"); tick();
        issue_dst_1 = 10; issue_valid_2 = 0; issue_wen_2 = 0;
        settle("t5_b"); tick();
        issue_dst_1 = 4; flush = 1;
        settle("t5_flush");
        check("t5_pend_before", 32'(pending_mask[10] & pending_mask[9] & pending_mask[2]), 32'd1);
        tick();
        idle();
        wb_valid_2 = 1; wb_dst_2 = 6;
        settle("t5_uf");
        check("t5_mask_after_flush", pending_mask, 32'd0);
        tick();
        idle();
        settle("t5_err");
        check("t5_err_set", 32'(sb_err), 32'd1);
        check("t5_mask6", 32'(pending_mask[6]), 32'd0);
        flush = 1;
        tick();
        flush = 0;
        settle("t5_err_sticky");
        check("t5_err_kept", 32'(sb_err), 32'd1);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            issue_valid_1 = ($urandom_range(0, 3) != 0);
            issue_valid_2 = ($urandom_range(0, 2) != 0);
            issue_src1_1  = 5'($urandom_range(0, 7));
            issue_src2_1  = 5'($urandom_range(0, 7));
            issue_src1_2  = 5'($urandom_range(0, 7));
            issue_src2_2  = 5'($urandom_range(0, 7));
            issue_rs_en_1 = 2'($urandom_range(0, 3));
            issue_rs_en_2 = 2'($urandom_range(0, 3));
            issue_dst_1   = 5'($urandom_range(0, 7));
            issue_dst_2   = 5'($urandom_range(0, 7));
            issue_wen_1   = ($urandom_range(0, 3) != 0);
            issue_wen_2   = ($urandom_range(0, 3) != 0);
            allow_in      = ($urandom_range(0, 4) != 0);
            wb_dst_1      = 5'($urandom_range(0, 7));
            wb_dst_2      = 5'($urandom_range(0, 7));
            wb_valid_1    = (mcnt[wb_dst_1] > 0) || ($urandom_range(0, 24) == 0);
            wb_valid_2    = (mcnt[wb_dst_2] > 0) || ($urandom_range(0, 24) == 0);
            flush         = ($urandom_range(0, 39) == 0);
            settle("rnd");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Dual-issue register scoreboard that gates the 2-read/2-write integer register file. It tracks in-flight writes per architectural register and grants issue per slot only when the operands are free. Granted writes are allocated on issue and retired on the two writeback ports. It sits between decode/issue and the register file, and drives the issue stage's per-slot go signals.

## Interface
- `NREG`, 32: number of architectural registers. Register 0 is never tracked.
- `CNT_W`, 2: width of the per-register in-flight counter. The maximum is `CMAX = 2^CNT_W - 1` (3).

- `clk` in 1: the only clock.
- `resetn` in 1: asynchronous, active-low reset.
- `issue_valid_1`, `issue_valid_2` in 1 each: the slot holds a valid instruction. Slot 1 is older.
- `issue_src1_1`, `issue_src2_1`, `issue_src1_2`, `issue_src2_2` in 5 each: source register numbers.
- `issue_rs_en_1`, `issue_rs_en_2` in 2 each: per-source use flags. Bit 0 is src1 and bit 1 is src2.
- `issue_dst_1`, `issue_dst_2` in 5 each: destination register numbers.
- `issue_wen_1`, `issue_wen_2` in 1 each: the slot writes its destination.
- `allow_in` in 1: the downstream stage accepts this cycle.
- `issue_ok_1`, `issue_ok_2` out 1 each: per-slot issue grant (combinational).
- `wb_valid_1`, `wb_valid_2` in 1 each: a writeback retires this cycle. This is the OR of the regfile byte write enables.
- `wb_dst_1`, `wb_dst_2` in 5 each: writeback register numbers.
- `flush` in 1: pipeline flush. It discards all in-flight allocations.
- `pending_mask` out 32: bit r = 1 when counter[r] != 0. Bit 0 is always 0. Registered.
- `sb_busy` out 1: OR of `pending_mask`. Registered.
- `sb_err` out 1: sticky underflow/overflow protocol error. Registered.

## Operation
**State**
- `cnt[r]`, `CNT_W` bits, for r = 1..31.
- r = 0 is hard-wired to 0. Issue or writeback to r0 neither allocates nor retires.

**Slot 1 grant.** `issue_ok_1` = `issue_valid_1` AND all of:
- Each enabled source with a nonzero register has `cnt == 0`.
- If `issue_wen_1` is set and the destination is nonzero, `cnt[dst_1] < CMAX`.

**Slot 2 grant.** `issue_ok_2` = `issue_ok_1` AND `issue_valid_2` AND all of:
- Slot 2's own source checks pass, as for slot 1.
- No intra-bundle RAW: no enabled slot 2 source equals `dst_1` while slot 1 writes a nonzero `dst_1`.
- Destination capacity:
  - If `dst_2 == dst_1` and both write, `cnt[dst] <= CMAX - 2`.
  - Otherwise `cnt[dst_2] < CMAX`.
- Slot 2 never issues alone. Issue is strictly in order.

**Fire and counter update**
- `fire_k = issue_ok_k & allow_in`.
- `inc[r]` = (`fire_1 & wen_1 & dst_1 == r`) + (`fire_2 & wen_2 & dst_2 == r`), range 0..2.
- `dec[r]` = (`wb_valid_1 & wb_dst_1 == r`) + (`wb_valid_2 & wb_dst_2 == r`), range 0..2.
- Next value: `cnt[r] <= cnt[r] + inc[r] - dec[r]`, computed in `CNT_W + 1` bits.
- Underflow: a result below 0 sets `sb_err`, and cnt saturates at 0.
- Overflow: a result above `CMAX` sets `sb_err`, and cnt saturates at `CMAX`. This is unreachable when the grant rules hold.

**Flush**
- Every counter becomes 0 on the next edge.
- Flush overrides issue and writeback in the same cycle.
- `sb_err` is not cleared by flush.

**Reset**
- Asynchronous, on `resetn == 0`: all counters are 0, `pending_mask` is 0, `sb_busy` is 0, `sb_err` is 0.
- `issue_ok_*` remain combinational and therefore follow their inputs during reset.

## Timing
- Grant is zero-cycle: `issue_ok_*` is a function of registered counters and current-cycle inputs only.
- A fired allocation is visible in `cnt`, `pending_mask` and grants starting the next cycle.
- No writeback-to-issue bypass:
  - A writeback retiring r in cycle t unblocks readers of r in cycle t+1.
  - The register file also writes at edge t, so the read in t+1 returns the new data.
- Issue and writeback to the same register in the same cycle apply net: `+inc - dec`.
- Two writebacks to the same register in one cycle decrement by 2.
- With `allow_in` low, `issue_ok_*` may still be high but nothing allocates.
- No outputs have a combinational path from `wb_*` or `flush`.

## Test plan
1. **Reset.** Hold `resetn` low, then release.
   - Expect `pending_mask = 0`, `sb_busy = 0`, `sb_err = 0`.
   - With `issue_valid_1 = 1` and src r5: `issue_ok_1 = 1`.
2. **RAW across cycles.** Cycle 0: slot 1 issues with `dst = r5` and `allow_in = 1`.
   - Cycle 1: `pending_mask[5] = 1`. A slot 1 read of r5 gives `issue_ok_1 = 0`.
   - Cycle 2: assert `wb_valid_1` with `wb_dst_1 = 5`. `issue_ok_1` is still 0 in cycle 2.
   - Cycle 3: `issue_ok_1 = 1` and `pending_mask[5] = 0`.
3. **Intra-bundle RAW.**
   - Slot 1 `dst = r7`, slot 2 `src2 = r7`, all counters 0: `issue_ok_1 = 1`, `issue_ok_2 = 0`.
   - Slot 2 `src2 = r8` instead: both grants are 1.
4. **Same-destination capacity and double retire.**
   - Preload `cnt[r3] = 1`. Both slots issue with `dst = r3`.
   - `issue_ok_2 = 1`, and `cnt[r3]` becomes 3.
   - Next bundle writing r3: `issue_ok_1 = 0`.
   - Dual writeback to r3 in one cycle: `cnt[r3]` becomes 1.
5. **Flush and error.**
   - With r2, r9 and r10 pending, assert `flush` together with a slot 1 issue to r4. Next cycle `pending_mask = 0`.
   - Then assert `wb_valid_2` with `wb_dst_2 = 6` while `cnt[r6] = 0`. Next cycle `sb_err = 1` and `cnt[r6] = 0`.
   - A later flush leaves `sb_err = 1`.
6. **Register 0.** Issue `dst = r0` and read `src = r0` repeatedly.
   - `pending_mask[0] = 0`, the grant is always 1, and `sb_err` stays 0.
